decode_sequencer: RTL

Registered multi-cycle sequencer next to the decode-stage control unit. It owns the state that spans several decode cycles: the LDM immediate word, RET/RTI flush bubbles, and the hardware interrupt entry sequence. It drives PC hold, forced-NOP and phase signals into the control unit and fetch stage. The combinational decoder stays purely per-cycle.

---
 rtl/decode_sequencer_pkg.sv | 30 +++
 rtl/decode_sequencer_int_pending.sv | 29 ++
 rtl/decode_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decode_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding, interrupt step codes and
// RET/RTI bubble counts for the decode sequencer.
package decode_sequencer_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_LDM = 5'h0c;
  localparam logic [4:0] OP_RET = 5'h1a;
  localparam logic [4:0] OP_RTI = 5'h1b;

  localparam int RET_BUBBLES = 2;
  localparam int RTI_BUBBLES = 3;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LDM_IMM   = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_INT_PC    = 3'd3,
    ST_INT_FLAGS = 3'd4,
    ST_INT_VEC   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEQ_NONE       = 2'd0,
    SEQ_PUSH_PC    = 2'd1,
    SEQ_PUSH_FLAGS = 2'd2,
    SEQ_VECTOR     = 2'd3
  } int_seq_e;

endpackage

// File: rtl/decode_sequencer_int_pending.sv
// Interrupt request edge detect and pending bit. The request output includes
// the edge seen this cycle so the sequencer can enter INT_PC one cycle later.
module int_pending (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_int,
  input  logic clr,
  output logic req,
  output logic pending
);

  logic ext_q;
  logic rise;

  assign rise = ext_int & ~ext_q;
  assign req  = pending | rise;

  // A new edge wins over clear so a request arriving during INT_VEC is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      ext_q   <= ext_int;
      pending <= rise | (pending & ~clr);
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Multi-cycle decode sequencer: LDM immediate phase, RET/RTI flush bubbles and
// the hardware interrupt entry sequence (present only when INT_SEQ_EN is defined).
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int FLUSH_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode_i,
  input  logic       valid_i,
  input  logic       flush_br_i,
  input  logic       ext_int_i,
  output logic       nop_o,
  output logic       pc_hold_o,
  output logic       imm_phase_o,
  output logic [1:0] int_seq_o,
  output logic       pc_sel_int_o,
  output logic       int_ack_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] cnt_q, cnt_d;
  logic               int_req;
  logic               is_ldm, is_ret, is_rti;

  assign is_ldm = valid_i && (opcode_i == OP_LDM);
  assign is_ret = valid_i && (opcode_i == OP_RET);
  assign is_rti = valid_i && (opcode_i == OP_RTI);

`ifdef INT_SEQ_EN
  logic int_pend;

  int_pending u_int_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .ext_int (ext_int_i),
    .clr     (state_q == ST_INT_VEC),
    .req     (int_req),
    .pending (int_pend)
  );
`else
  logic unused_ext_int;
  assign unused_ext_int = ext_int_i;
  assign int_req        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nop_o        = 1'b0;
    pc_hold_o    = 1'b0;
    imm_phase_o  = 1'b0;
    int_seq_o    = SEQ_NONE;
    pc_sel_int_o = 1'b0;
    int_ack_o    = 1'b0;
    case (state_q)
      ST_RUN: begin
        nop_o = flush_br_i;
        // An LDM must keep its immediate word paired, so it outranks the interrupt.
        if (flush_br_i)             state_d = ST_RUN;
        else if (int_req && !is_ldm) state_d = ST_INT_PC;
        else if (is_ldm)            state_d = ST_LDM_IMM;
        else if (is_ret) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_W'(RET_BUBBLES);
        end else if (is_rti) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_W'(RTI_BUBBLES);
        end
      end
      ST_LDM_IMM: begin
        imm_phase_o = 1'b1;
        nop_o       = flush_br_i;
        state_d     = ST_RUN;
      end
      ST_FLUSH: begin
        nop_o     = 1'b1;
        pc_hold_o = 1'b1;
        if (flush_br_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - FLUSH_W'(1);
          if (cnt_q <= FLUSH_W'(1)) state_d = ST_RUN;
        end
      end
`ifdef INT_SEQ_EN
      ST_INT_PC: begin
        nop_o     = 1'b1;
        pc_hold_o = 1'b1;
        int_seq_o = SEQ_PUSH_PC;
        state_d   = ST_INT_FLAGS;
      end
      ST_INT_FLAGS: begin
        nop_o     = 1'b1;
        pc_hold_o = 1'b1;
        int_seq_o = SEQ_PUSH_FLAGS;
        state_d   = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        nop_o        = 1'b1;
        int_seq_o    = SEQ_VECTOR;
        pc_sel_int_o = 1'b1;
        int_ack_o    = 1'b1;
        state_d      = ST_RUN;
      end
`endif
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o  = (state_q != ST_RUN);
  assign state_o = state_q;

endmodule
